// File: rtl/psel_unpacker.sv
// Streams a captured WIDTH-bit word out as WIDTH/SLICE part-selects, LSB slice first,
// optionally restoring the bit order that the capture side stored reversed.
module psel_unpacker #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SLICE   = 1,
    parameter int unsigned REVERSE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [SLICE-1:0] o_slice,
    output logic [SLICE-1:0] o_slice_n,
    output logic             o_last,
    output logic             o_busy
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] unpacked;

    always_comb begin
        unpacked = '0;
        for (int k = 0; k < WIDTH; k++) begin
            unpacked[k] = (REVERSE != 0) ? i_data[WIDTH-1-k] : i_data[k];
        end
    end

    assign o_valid   = (state_q == StSend);
    assign o_busy    = (state_q == StSend);
    assign o_last    = (state_q == StSend) && (idx_q == LAST_IDX);
    // Combinational from i_ready: lets the next word land on the last slice's handshake.
    assign o_ready   = (state_q == StIdle) || (o_last && i_ready);
    assign o_slice   = word_q[int'(idx_q) * SLICE +: SLICE];
    assign o_slice_n = ~o_slice;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        word_q  <= unpacked;
                        idx_q   <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (i_ready) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q <= idx_q + 1'b1;
                        end else if (i_valid) begin
                            word_q <= unpacked;
                            idx_q  <= '0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psel_unpacker.sv
// Scoreboard bench for psel_unpacker: a reversing 1-bit build and a pass-through 2-bit build.
module tb_psel_unpacker;

    logic clk;
    logic rst_n;

    logic       a_valid, a_rdy, a_o_ready, a_o_valid, a_last, a_busy;
    logic [3:0] a_data;
    logic [0:0] a_slice, a_slice_n;

    logic       b_valid, b_rdy, b_o_ready, b_o_valid, b_last, b_busy;
    logic [3:0] b_data;
    logic [1:0] b_slice, b_slice_n;

    int vectors;
    int miscompares;

    // Entries are {last, slice}; slice zero-extended to 2 bits.
    logic [2:0] qa[$];
    logic [2:0] qb[$];

    psel_unpacker #(.WIDTH(4), .SLICE(1), .REVERSE(1)) dut_a (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (a_valid),
        .o_ready   (a_o_ready),
        .i_data    (a_data),
        .o_valid   (a_o_valid),
        .i_ready   (a_rdy),
        .o_slice   (a_slice),
        .o_slice_n (a_slice_n),
        .o_last    (a_last),
        .o_busy    (a_busy)
    );

    psel_unpacker #(.WIDTH(4), .SLICE(2), .REVERSE(0)) dut_b (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (b_valid),
        .o_ready   (b_o_ready),
        .i_data    (b_data),
        .o_valid   (b_o_valid),
        .i_ready   (b_rdy),
        .o_slice   (b_slice),
        .o_slice_n (b_slice_n),
        .o_last    (b_last),
        .o_busy    (b_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [2:0] e;
        if (rst_n && a_o_valid && a_rdy) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected_slice: got slice=%b last=%b, required no output",
                         a_slice, a_last);
            end else begin
                e = qa.pop_front();
                if (a_slice !== e[0:0] || a_slice_n !== ~e[0:0] || a_last !== e[2]) begin
                    miscompares++;
                    $display("FAIL a_slice: got slice=%b slice_n=%b last=%b, required %b/%b/%b",
                             a_slice, a_slice_n, a_last, e[0:0], ~e[0:0], e[2]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (rst_n && b_o_valid && b_rdy) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected_slice: got slice=%b last=%b, required no output",
                         b_slice, b_last);
            end else begin
                e = qb.pop_front();
                if (b_slice !== e[1:0] || b_slice_n !== ~e[1:0] || b_last !== e[2]) begin
                    miscompares++;
                    $display("FAIL b_slice: got slice=%b slice_n=%b last=%b, required %b/%b/%b",
                             b_slice, b_slice_n, b_last, e[1:0], ~e[1:0], e[2]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((qa.size() != 0 || a_o_valid) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("a_drain", {3'b0, (qa.size() == 0 && !a_o_valid)}, 4'd1);
    endtask

    task automatic drain_b();
        int n = 0;
        while ((qb.size() != 0 || b_o_valid) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("b_drain", {3'b0, (qb.size() == 0 && !b_o_valid)}, 4'd1);
    endtask

    task automatic check_a_reset();
        check("a_rst_valid",   {3'b0, a_o_valid}, 4'd0);
        check("a_rst_busy",    {3'b0, a_busy},    4'd0);
        check("a_rst_ready",   {3'b0, a_o_ready}, 4'd1);
        check("a_rst_last",    {3'b0, a_last},    4'd0);
        check("a_rst_slice",   {3'b0, a_slice},   4'd0);
        check("a_rst_slice_n", {3'b0, a_slice_n}, 4'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 1;
        a_valid = 0; a_rdy = 0; a_data = '0;
        b_valid = 0; b_rdy = 0; b_data = '0;
        vectors = 0; miscompares = 0;

        #1 rst_n = 0;
        #1;
        check_a_reset();
        check("b_rst_slice",   {2'b0, b_slice},   4'd0);
        check("b_rst_slice_n", {2'b0, b_slice_n}, 4'b0011);
        check("b_rst_ready",   {3'b0, b_o_ready}, 4'd1);
        step();
        step();
        rst_n = 1;

        // 4'b0001 reversed: u[k] = d[3-k] -> slices 0,0,0,1
        a_valid = 1; a_data = 4'b0001; a_rdy = 1;
        qa.push_back(3'b000); qa.push_back(3'b000);
        qa.push_back(3'b000); qa.push_back(3'b101);
        step();
        check("a_latency_valid", {3'b0, a_o_valid}, 4'd1);
        check("a_busy",          {3'b0, a_busy},    4'd1);
        a_valid = 0;
        drain_a();

        // Back-to-back: 4'hA -> 1,0,1,0 then 4'h3 -> 0,0,1,1
        a_valid = 1; a_data = 4'hA;
        qa.push_back(3'b001); qa.push_back(3'b000);
        qa.push_back(3'b001); qa.push_back(3'b100);
        qa.push_back(3'b000); qa.push_back(3'b000);
        qa.push_back(3'b001); qa.push_back(3'b101);
        step();
        a_data = 4'h3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("a_b2b_valid_c%0d", c), {3'b0, a_o_valid}, 4'd1);
            if (c < 8) check($sformatf("a_b2b_ready_c%0d", c), {3'b0, a_o_ready},
                             {3'b0, (c == 4)});
            @(posedge clk);
            #1;
            if (c == 4) a_valid = 0;
        end
        check("a_b2b_idle", {3'b0, a_o_valid}, 4'd0);

        // Stall on slice 1 of 4'b0110 -> 0,1,1,0; i_data changes must be ignored
        a_valid = 1; a_data = 4'b0110;
        qa.push_back(3'b000); qa.push_back(3'b001);
        qa.push_back(3'b001); qa.push_back(3'b100);
        step();
        a_valid = 0;
        step();
        a_rdy = 0; a_valid = 1; a_data = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("a_stall_slice",   {3'b0, a_slice},   4'd1);
            check("a_stall_slice_n", {3'b0, a_slice_n}, 4'd0);
            check("a_stall_ready",   {3'b0, a_o_ready}, 4'd0);
            @(posedge clk);
            #1;
            a_data = a_data - 4'd1;
        end
        a_rdy = 1; a_valid = 0;
        drain_a();

        // Reset while slice 2 of 4'b1011 (1,0,1,1) is on the output
        a_valid = 1; a_data = 4'b1011;
        qa.push_back(3'b001); qa.push_back(3'b000);
        qa.push_back(3'b001); qa.push_back(3'b101);
        step();
        a_valid = 0;
        step();
        step();
        a_rdy = 0;
        #2 rst_n = 0;
        #1;
        check_a_reset();
        qa.delete();
        step();
        step();
        rst_n = 1;
        a_rdy = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("a_post_rst_valid", {3'b0, a_o_valid}, 4'd0);
            check("a_post_rst_busy",  {3'b0, a_busy},    4'd0);
        end
        step();
        // 4'b1000 reversed -> 1,0,0,0
        a_valid = 1; a_data = 4'b1000;
        qa.push_back(3'b001); qa.push_back(3'b000);
        qa.push_back(3'b000); qa.push_back(3'b100);
        step();
        a_valid = 0;
        drain_a();

        // Pass-through, 2-bit slices: 4'b1101 -> 01, 11
        b_valid = 1; b_data = 4'b1101; b_rdy = 1;
        qb.push_back(3'b001); qb.push_back(3'b111);
        step();
        check("b_latency_valid", {3'b0, b_o_valid}, 4'd1);
        b_valid = 0;
        drain_b();

        // 4'b0110 -> 10, 01 with a one-cycle stall on the first slice
        b_valid = 1; b_data = 4'b0110;
        qb.push_back(3'b010); qb.push_back(3'b101);
        step();
        b_valid = 0; b_rdy = 0;
        step();
        check("b_stall_slice", {2'b0, b_slice}, 4'b0010);
        b_rdy = 1;
        drain_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
